// File: rtl/router_pkg.sv
// Shared defaults and header field helpers for the router register stage.
package router_pkg;

  localparam int unsigned DefW        = 8;
  localparam int unsigned DefAw       = 2;
  localparam int unsigned DefNumPorts = 3;
  localparam int unsigned DefCntW     = 8;

  // Helpers work on a zero-extended header so any W up to MaxW can use them.
  localparam int unsigned MaxW = 64;

  // Source of the next dout value.
  typedef enum logic [1:0] {
    DoutKeep,
    DoutHeader,
    DoutData,
    DoutHold
  } dout_sel_e;

  // Address field: header[aw-1:0].
  function automatic logic [MaxW-1:0] hdr_addr(logic [MaxW-1:0] hdr, int unsigned aw);
    return hdr & ((MaxW'(1) << aw) - MaxW'(1));
  endfunction

  // Length field: header[W-1:aw] (upper bits are zero from the extension).
  function automatic logic [MaxW-1:0] hdr_len(logic [MaxW-1:0] hdr, int unsigned aw);
    return hdr >> aw;
  endfunction

  function automatic logic addr_valid(logic [MaxW-1:0] hdr, int unsigned aw,
                                      int unsigned num_ports);
    return hdr_addr(hdr, aw) < MaxW'(num_ports);
  endfunction

endpackage

// File: rtl/router_reg_param_if.sv
// FSM/source/FIFO side signals of the router register stage.
interface router_reg_param_if
  import router_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned CNT_W = DefCntW
) ();

  logic             pkt_valid;
  logic [W-1:0]     data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             rst_int_reg;
  logic [W-1:0]     dout;
  logic             parity_done;
  logic             low_packet_valid;
  logic             err;
  logic             len_err;
  logic [CNT_W-1:0] err_count;

  // Driven by the router FSM / source side.
  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, len_err, err_count
  );

  // The register stage itself.
  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, len_err, err_count
  );

endinterface

// File: rtl/router_chk_acc.sv
// Running parity / payload length accumulator and end-of-packet compare.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned AW = DefAw
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         lfd_i,
  input  logic         ld_i,
  input  logic         full_state_i,
  input  logic         pkt_valid_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] header_i,
  input  logic         chk_i,
  output logic         err_o,
  output logic         len_err_o,
  output logic         chk_fail_o
);

  localparam int unsigned LenW = W - AW;

  logic [W-1:0]    int_par_q;
  logic [W-1:0]    pkt_par_q;
  logic [LenW-1:0] beat_cnt_q;
  logic [LenW-1:0] len_field;
  logic            err_q;
  logic            len_err_q;
  logic            par_mis;
  logic            len_mis;

  assign len_field  = LenW'(hdr_len(MaxW'(header_i), AW));
  assign par_mis    = (int_par_q != pkt_par_q);
  assign len_mis    = (beat_cnt_q != len_field);
  assign chk_fail_o = chk_i & (par_mis | len_mis);
  assign err_o      = err_q;
  assign len_err_o  = len_err_q;

  // Accumulate parity over header + payload, count payload beats, latch parity beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_par_q  <= '0;
      beat_cnt_q <= '0;
      pkt_par_q  <= '0;
    end else begin
      if (clr_i) begin
        int_par_q  <= '0;
        beat_cnt_q <= '0;
      end else if (lfd_i) begin
        int_par_q <= int_par_q ^ header_i;
      end else if (ld_i && pkt_valid_i && !full_state_i) begin
        int_par_q <= int_par_q ^ data_i;
        if (beat_cnt_q != '1) begin
          beat_cnt_q <= beat_cnt_q + LenW'(1);
        end
      end
      if (ld_i && !pkt_valid_i) begin
        pkt_par_q <= data_i;
      end
    end
  end

  // Error flags: the compare strobe wins so a result is never lost to a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else if (chk_i) begin
      err_q     <= par_mis;
      len_err_q <= len_mis;
    end else if (clr_i) begin
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
    end
  end

endmodule

// File: rtl/router_reg_param.sv
// Router byte-register stage: header latch, full-FIFO hold, dout mux, error count.
module router_reg_param
  import router_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned AW        = DefAw,
  parameter int unsigned NUM_PORTS = DefNumPorts,
  parameter int unsigned CNT_W     = DefCntW
) (
  input logic              clock,
  input logic              resetn,
  router_reg_param_if.slave bus
);

  logic [W-1:0]     header_q;
  logic [W-1:0]     hold_q;
  logic [W-1:0]     dout_q;
  logic             parity_done_q;
  logic             parity_done_d1_q;
  logic             lpv_q;
  logic [CNT_W-1:0] err_count_q;
  dout_sel_e        dout_sel;
  logic             hdr_ok;
  logic             chk;
  logic             chk_fail;
  logic             err;
  logic             len_err;

  assign hdr_ok = bus.detect_add & bus.pkt_valid & addr_valid(MaxW'(bus.data_in), AW, NUM_PORTS);
  // Compare fires exactly once, the cycle after parity_done rises.
  assign chk    = parity_done_q & ~parity_done_d1_q;

  // dout source priority: header, then live data (unless the FIFO is full), then held beat.
  always_comb begin
    dout_sel = DoutKeep;
    if (bus.lfd_state) begin
      dout_sel = DoutHeader;
    end else if (bus.ld_state) begin
      dout_sel = bus.fifo_full ? DoutKeep : DoutData;
    end else if (bus.laf_state) begin
      dout_sel = DoutHold;
    end
  end

  // Header latch, stalled-beat hold register and output register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q <= '0;
      hold_q   <= '0;
      dout_q   <= '0;
    end else begin
      if (hdr_ok) begin
        header_q <= bus.data_in;
      end
      if (bus.ld_state && bus.fifo_full) begin
        hold_q <= bus.data_in;
      end
      case (dout_sel)
        DoutHeader: dout_q <= header_q;
        DoutData:   dout_q <= bus.data_in;
        DoutHold:   dout_q <= hold_q;
        default:    dout_q <= dout_q;
      endcase
    end
  end

  // Packet-end tracking: source finished, parity beat consumed, and its delayed copy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lpv_q            <= 1'b0;
      parity_done_q    <= 1'b0;
      parity_done_d1_q <= 1'b0;
    end else begin
      if (bus.rst_int_reg) begin
        lpv_q <= 1'b0;
      end else if (bus.ld_state && !bus.pkt_valid) begin
        lpv_q <= 1'b1;
      end
      if (bus.detect_add) begin
        parity_done_q <= 1'b0;
      end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                   (bus.laf_state && lpv_q && !parity_done_q)) begin
        parity_done_q <= 1'b1;
      end
      parity_done_d1_q <= parity_done_q;
    end
  end

  // Saturating count of packets that failed parity or length.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_count_q <= '0;
    end else if (chk_fail && (err_count_q != '1)) begin
      err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  router_chk_acc #(
    .W  (W),
    .AW (AW)
  ) u_chk_acc (
    .clk_i        (clock),
    .rst_ni       (resetn),
    .clr_i        (bus.detect_add),
    .lfd_i        (bus.lfd_state),
    .ld_i         (bus.ld_state),
    .full_state_i (bus.full_state),
    .pkt_valid_i  (bus.pkt_valid),
    .data_i       (bus.data_in),
    .header_i     (header_q),
    .chk_i        (chk),
    .err_o        (err),
    .len_err_o    (len_err),
    .chk_fail_o   (chk_fail)
  );

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = lpv_q;
  assign bus.err              = err;
  assign bus.len_err          = len_err;
  assign bus.err_count        = err_count_q;

endmodule
